sparse_im_stream: RTL and testbench
===================================

Name: sparse_im_stream

Overview:
- Parametrised, programmable item memory for segmented sparse hypervectors.
- Each item HV holds exactly one active bit per segment. Only the bit positions are stored, never the full 4096-bit vectors.
- On request, the block streams the selected item HV to the encoder datapath in fixed-width beats under valid/ready.
- Replaces hard-coded, combinational IM constants with a table written at configuration time.

Parameters:
- HV_DIM, 4096, hypervector width in bits.
- SEG_LEN, 64, segment length. One active bit per segment; must divide HV_DIM.
- M, 16, number of item HVs stored.
- BEAT_SEGS, 4, segments emitted per output beat; must divide NSEG.
- Derived, not overridable: NSEG=HV_DIM/SEG_LEN, PW=$clog2(SEG_LEN), BEATS=NSEG/BEAT_SEGS, BW=BEAT_SEGS*SEG_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  position-table write strobe.
- cfg_item  in  $clog2(M)  item index to write.
- cfg_seg  in  $clog2(NSEG)  segment index to write.
- cfg_pos  in  PW  active-bit position within the segment.
- req_valid  in  1  stream request.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_item  in  $clog2(M)  item to stream.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  BW  beat payload. Bit k*SEG_LEN+p is global HV bit (beat*BW)+k*SEG_LEN+p.
- out_beat  out  $clog2(BEATS)  index of the current beat.
- out_last  out  1  high on beat BEATS-1.
- busy  out  1  high while not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset nrst is asynchronous, active-low.
- Reset values:
  - All table entries = 0.
  - State IDLE.
  - out_valid=0, out_data=0, out_beat=0, out_last=0, busy=0.
  - req_ready=1 (combinational, see below).
- Table: M*NSEG entries of PW bits.
  - A write takes effect when cfg_we=1 and state==IDLE; it is visible to any request accepted on a later cycle.
  - cfg_we is ignored while busy.
- req_ready = (state==IDLE) && !cfg_we. A config write and a request never coincide.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM on req_valid && req_ready. The block latches req_item and sets beat=0.
  - STREAM holds out_valid=1.
  - On out_valid && out_ready with beat<BEATS-1, beat increments and the next beat's data registers the following cycle. There are no bubbles under continuous out_ready.
  - On acceptance of the last beat: STREAM -> IDLE, out_valid=0. A new request may be accepted in the very next cycle.
- Latency: the first beat is valid 1 cycle after request acceptance. A full HV takes BEATS cycles with no stall; minimum request-to-request spacing is BEATS+1 cycles.
- Decode, for each k in 0..BEAT_SEGS-1:
  - g = beat*BEAT_SEGS+k.
  - The out_data segment k is one-hot at table[item][g].
  - Each beat therefore carries exactly BEAT_SEGS set bits.
- Backpressure: while out_valid && !out_ready, out_data, out_beat and out_last hold stable.
- out_last = out_valid && (out_beat==BEATS-1).
- Reset asserted mid-stream: immediate return to IDLE with all outputs at reset values and the table cleared. No partial stream resumes.
- Out-of-range indices (cfg_item or req_item >= M, when M is not a power of two): writes are dropped; a request streams all-zero beats.

Optional Feature:
- Macro: SPARSE_IM_SEG_ROTATE_EN.
- Defined:
  - Adds input req_rot, width $clog2(NSEG), latched at request acceptance.
  - Segment g uses table[item][(g - rot) mod NSEG], a cyclic segment-level rotation used as the n-gram permutation.
  - Wrap-around is mandatory (NSEG need not be a power of two; reduce explicitly).
- Undefined: port absent; behaviour is identical to rot=0.

Test Plan:
- Reset, then hold nrst=1 with no stimulus -> req_ready=1, busy=0, out_valid=0, out_data=0.
- Write item 3 positions seg g = g mod 64, then request item 3 with out_ready=1:
  - 16 consecutive beats.
  - Beat b segment k has bit (4b+k) set.
  - out_last only on beat 15.
  - busy drops the cycle after.
- Same stream, with out_ready deasserted for 3 cycles at beat 5 -> beat 5 data held for 4 cycles; subsequent beats unchanged; total 19 valid cycles.
- Pulse cfg_we (item 3, seg 0, pos 7) during STREAM, then re-request item 3 -> stream unchanged (seg 0 still pos 0). Pulse again in IDLE -> next stream shows seg 0 pos 7.
- Assert nrst low during beat 8 -> outputs zero immediately. After release, request item 3 -> beat 0 segments all at position 0 (table cleared).
- With SPARSE_IM_SEG_ROTATE_EN, item 3 as above and req_rot=1 -> segment 0 at position 63, segment 1 at position 0 (wrap verified).

Source files
------------

// File: rtl/sparse_im_stream.sv
// Programmable item memory for segmented sparse HVs: stores one active-bit position per
// segment and streams the selected item as one-hot beats. Optional macro: SPARSE_IM_SEG_ROTATE_EN.

module sparse_im_seg_dec #(
    parameter int SEG_LEN = 64,
    parameter int PW      = 6
) (
    input  logic               en,
    input  logic [PW-1:0]      pos,
    output logic [SEG_LEN-1:0] seg
);
    always_comb begin
        seg = '0;
        if (en) seg[pos] = 1'b1;
    end
endmodule

module sparse_im_stream #(
    parameter  int HV_DIM    = 4096,
    parameter  int SEG_LEN   = 64,
    parameter  int M         = 16,
    parameter  int BEAT_SEGS = 4,
    localparam int NSEG      = HV_DIM / SEG_LEN,
    localparam int PW        = $clog2(SEG_LEN),
    localparam int BEATS     = NSEG / BEAT_SEGS,
    localparam int BW        = BEAT_SEGS * SEG_LEN,
    localparam int IW        = (M > 1) ? $clog2(M) : 1,
    localparam int SW        = (NSEG > 1) ? $clog2(NSEG) : 1,
    localparam int BTW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           cfg_we,
    input  logic [IW-1:0]  cfg_item,
    input  logic [SW-1:0]  cfg_seg,
    input  logic [PW-1:0]  cfg_pos,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [IW-1:0]  req_item,
`ifdef SPARSE_IM_SEG_ROTATE_EN
    input  logic [SW-1:0]  req_rot,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BW-1:0]  out_data,
    output logic [BTW-1:0] out_beat,
    output logic           out_last,
    output logic           busy
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state;
    logic [PW-1:0] tbl [M][NSEG];
    logic [IW-1:0] item_q;
    logic [SW-1:0] rot_q;
    logic [SW-1:0] rot_in;

`ifdef SPARSE_IM_SEG_ROTATE_EN
    assign rot_in = req_rot;
`else
    assign rot_in = '0;
`endif

    assign req_ready = (state == IDLE) && !cfg_we;
    assign busy      = (state == STREAM);

    logic accept;
    assign accept = req_valid && req_ready;

    // Next beat's selectors: at acceptance they come straight from the request.
    logic [IW-1:0]  nx_item;
    logic [SW-1:0]  nx_rot;
    logic [BTW-1:0] nx_beat;
    assign nx_item = accept ? req_item : item_q;
    assign nx_rot  = accept ? rot_in   : rot_q;
    assign nx_beat = accept ? '0 : BTW'(out_beat + 1'b1);

    logic [BEAT_SEGS-1:0][SEG_LEN-1:0] nx_data;

    for (genvar k = 0; k < BEAT_SEGS; k++) begin : g_seg
        logic [SW-1:0] src;
        logic [PW-1:0] pos;
        logic          en;
        always_comb begin
            int g, s;
            g   = int'(nx_beat) * BEAT_SEGS + k;
            // NSEG need not be a power of two, so wrap the rotation explicitly
            s   = g - (int'(nx_rot) % NSEG);
            if (s < 0) s = s + NSEG;
            src = SW'(s);
            en  = int'(nx_item) < M;
            pos = en ? tbl[nx_item][src] : '0;
        end
        sparse_im_seg_dec #(.SEG_LEN(SEG_LEN), .PW(PW)) u_dec (
            .en  (en),
            .pos (pos),
            .seg (nx_data[k])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
            item_q    <= '0;
            rot_q     <= '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < NSEG; j++)
                    tbl[i][j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we && int'(cfg_item) < M && int'(cfg_seg) < NSEG)
                        tbl[cfg_item][cfg_seg] <= cfg_pos;
                    if (accept) begin
                        state     <= STREAM;
                        item_q    <= req_item;
                        rot_q     <= rot_in;
                        out_valid <= 1'b1;
                        out_data  <= nx_data;
                        out_beat  <= '0;
                        out_last  <= (BEATS == 1);
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_beat == BTW'(BEATS - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_beat  <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            out_beat  <= nx_beat;
                            out_data  <= nx_data;
                            out_last  <= (nx_beat == BTW'(BEATS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_im_stream.sv
// Randomized self-checking bench for sparse_im_stream against a whole-HV reference model.

module tb_sparse_im_stream;
    localparam int HV_DIM = 4096, SEG_LEN = 64, M = 16, BEAT_SEGS = 4;
    localparam int NSEG = HV_DIM / SEG_LEN, BEATS = NSEG / BEAT_SEGS, BW = BEAT_SEGS * SEG_LEN;

    logic          clk = 0, nrst = 0;
    logic          cfg_we = 0;
    logic [3:0]    cfg_item = 0;
    logic [5:0]    cfg_seg = 0;
    logic [5:0]    cfg_pos = 0;
    logic          req_valid = 0;
    logic          req_ready;
    logic [3:0]    req_item = 0;
`ifdef SPARSE_IM_SEG_ROTATE_EN
    logic [5:0]    req_rot = 0;
`endif
    logic          out_valid;
    logic          out_ready = 1;
    logic [BW-1:0] out_data;
    logic [3:0]    out_beat;
    logic          out_last;
    logic          busy;

    int errors = 0, checks = 0;
    int mtbl [M][NSEG];

    always #5 clk = ~clk;

    sparse_im_stream #(.HV_DIM(HV_DIM), .SEG_LEN(SEG_LEN), .M(M), .BEAT_SEGS(BEAT_SEGS)) dut (
        .clk(clk), .nrst(nrst), .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_seg(cfg_seg),
        .cfg_pos(cfg_pos), .req_valid(req_valid), .req_ready(req_ready), .req_item(req_item),
`ifdef SPARSE_IM_SEG_ROTATE_EN
        .req_rot(req_rot),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beat(out_beat), .out_last(out_last), .busy(busy)
    );

    // Full HV from the model table: segment g set at position table[item][(g-rot) mod NSEG]
    function automatic logic [HV_DIM-1:0] model_hv(input int item, input int rot);
        logic [HV_DIM-1:0] v;
        v = '0;
        for (int g = 0; g < NSEG; g++)
            v[g*SEG_LEN + mtbl[item][((g - rot) % NSEG + NSEG) % NSEG]] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < NSEG; j++) mtbl[i][j] = 0;
    endtask

    // Called at a negedge with the DUT idle
    task automatic cfg_write(input int item, input int seg, input int pos);
        cfg_we = 1; cfg_item = 4'(item); cfg_seg = 6'(seg); cfg_pos = 6'(pos);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_blocks_req: req_ready=%b want 0", req_ready);
        end
        @(negedge clk);
        cfg_we = 0;
        mtbl[item][seg] = pos;
    endtask

    // Called at a negedge; returns at the negedge after the last beat was accepted
    task automatic stream_chk(input string name, input int item, input int rot,
                              input int stall_beat, input int stall_len, input bit rnd_stall,
                              input int poke_beat, output int vcyc);
        logic [HV_DIM-1:0] hv;
        int b, stall_left;
        bit done, poked;
        hv = model_hv(item, rot);
        req_valid = 1; req_item = 4'(item);
`ifdef SPARSE_IM_SEG_ROTATE_EN
        req_rot = 6'(rot);
`endif
        @(negedge clk);
        req_valid = 0;
        b = 0; vcyc = 0; stall_left = stall_len; done = 0; poked = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_beat !== 4'(b) ||
                out_last !== (b == BEATS-1) || out_data !== hv[b*BW +: BW]) begin
                errors++;
                $display("FAIL %s beat %0d: valid=%b busy=%b beat=%0d last=%b data=%h want data=%h",
                         name, b, out_valid, busy, out_beat, out_last, out_data, hv[b*BW +: BW]);
            end
            vcyc++;
            if (b == stall_beat && stall_left > 0) begin
                out_ready = 0; stall_left--;
            end else if (rnd_stall && $urandom_range(3) == 0) out_ready = 0;
            else out_ready = 1;
            cfg_we = (b == poke_beat && !poked);
            if (cfg_we) begin
                poked = 1; cfg_item = 3; cfg_seg = 0; cfg_pos = 7;
            end
            @(negedge clk);
            cfg_we = 0;
            if (out_ready) begin
                if (b == BEATS-1) done = 1;
                b++;
            end
        end
        out_ready = 1;
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: stream did not complete, beat=%0d", name, b);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: valid=%b busy=%b req_ready=%b want 0 0 1", name, out_valid, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: %b want 1", req_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b want 0", out_valid); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: %h want 0", out_data); end
        checks++; if (out_beat !== 4'd0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_beat_last: beat=%0d last=%b want 0 0", out_beat, out_last);
        end
    endtask

    task automatic test_stream();
        int v;
        for (int g = 0; g < NSEG; g++) cfg_write(3, g, g % SEG_LEN);
        stream_chk("stream_item3", 3, 0, -1, 0, 0, -1, v);
        checks++; if (v != BEATS) begin errors++; $display("FAIL stream_cycles: %0d want %0d", v, BEATS); end
    endtask

    task automatic test_backpressure();
        int v;
        stream_chk("stall_beat5", 3, 0, 5, 3, 0, -1, v);
        checks++; if (v != 19) begin errors++; $display("FAIL stall_cycles: %0d want 19", v); end
    endtask

    task automatic test_cfg_busy();
        int v;
        stream_chk("cfg_during_stream", 3, 0, -1, 0, 0, 2, v);
        stream_chk("after_ignored_cfg", 3, 0, -1, 0, 0, -1, v);
        checks++;
        if (mtbl[3][0] != 0) begin errors++; $display("FAIL model_seg0: %0d want 0", mtbl[3][0]); end
        cfg_write(3, 0, 7);
        stream_chk("after_idle_cfg", 3, 0, -1, 0, 0, -1, v);
    endtask

    task automatic test_back_to_back();
        int v;
        for (int i = 0; i < 40; i++)
            cfg_write($urandom_range(M-1), $urandom_range(NSEG-1), $urandom_range(SEG_LEN-1));
        for (int n = 0; n < 6; n++) begin
            int it, rt;
            it = $urandom_range(M-1);
`ifdef SPARSE_IM_SEG_ROTATE_EN
            rt = $urandom_range(NSEG-1);
`else
            rt = 0;
`endif
            stream_chk("random_b2b", it, rt, -1, 0, (n % 2) == 1, -1, v);
        end
    endtask

    task automatic test_reset_midstream();
        logic [BW-1:0] exp0;
        int v;
        bool_wait: begin
            req_valid = 1; req_item = 3;
`ifdef SPARSE_IM_SEG_ROTATE_EN
            req_rot = 0;
`endif
            @(negedge clk);
            req_valid = 0;
            for (int c = 0; c < 30 && out_beat != 4'd8; c++) @(negedge clk);
        end
        checks++;
        if (out_beat !== 4'd8) begin errors++; $display("FAIL midreset_reach_beat8: beat=%0d", out_beat); end
        #2 nrst = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_beat !== 4'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b data=%h beat=%0d last=%b busy=%b rdy=%b",
                     out_valid, out_data, out_beat, out_last, busy, req_ready);
        end
        model_clear();
        @(negedge clk);
        nrst = 1;
        @(negedge clk);
        exp0 = '0;
        for (int k = 0; k < BEAT_SEGS; k++) exp0[k*SEG_LEN] = 1'b1;
        req_valid = 1; req_item = 3;
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp0) begin
            errors++; $display("FAIL cleared_beat0: valid=%b data=%h want %h", out_valid, out_data, exp0);
        end
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        stream_chk("after_clear", 3, 0, -1, 0, 0, -1, v);
    endtask

`ifdef SPARSE_IM_SEG_ROTATE_EN
    task automatic test_rotate();
        int v;
        for (int g = 0; g < NSEG; g++) cfg_write(3, g, g % SEG_LEN);
        req_valid = 1; req_item = 3; req_rot = 1;
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (out_data[63] !== 1'b1 || out_data[SEG_LEN + 0] !== 1'b1) begin
            errors++; $display("FAIL rot_wrap: seg0 bit63=%b seg1 bit0=%b want 1 1", out_data[63], out_data[SEG_LEN]);
        end
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        stream_chk("rot1", 3, 1, -1, 0, 0, -1, v);
    endtask
`endif

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        nrst = 1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_cfg_busy();
        test_back_to_back();
        test_reset_midstream();
`ifdef SPARSE_IM_SEG_ROTATE_EN
        test_rotate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
